// File: rtl/sdf_twiddle_addr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_twiddle_addr_gen_if
//  Description : Bundle between a radix-2^2 SDF stage controller and its
//                twiddle sequencer. The sequencer takes the stage
//                frame-restart and data-enable. It returns the twiddle number,
//                its multiplier class, the block-end flag and the delayed
//                converted-twiddle valid.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals (named from the sequencer's point of view)
//    i_clear    : synchronous frame restart
//    i_di_en    : input sample valid for this stage
//    o_tw_en    : o_tw_addr / o_tw_sel valid
//    o_tw_addr  : twiddle number, LOG_N bits
//    o_tw_sel   : twiddle multiplier class 0..3
//    o_tw_last  : last sample of a stage block
//    o_val_en   : o_tw_en delayed to match the ROM/converter latency
//  Modports
//    slave  : the sequencer itself
//    master : the stage controller that drives it
// ============================================================================
interface sdf_twiddle_addr_gen_if #(
  parameter int LOG_N = 6
);
  logic             i_clear;
  logic             i_di_en;
  logic             o_tw_en;
  logic [LOG_N-1:0] o_tw_addr;
  logic [1:0]       o_tw_sel;
  logic             o_tw_last;
  logic             o_val_en;

  modport slave (
    input  i_clear,
    input  i_di_en,
    output o_tw_en,
    output o_tw_addr,
    output o_tw_sel,
    output o_tw_last,
    output o_val_en
  );

  modport master (
    output i_clear,
    output i_di_en,
    input  o_tw_en,
    input  o_tw_addr,
    input  o_tw_sel,
    input  o_tw_last,
    input  o_val_en
  );
endinterface
`default_nettype wire

// File: rtl/sdf_twiddle_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_twiddle_addr_gen
//  Description : Twiddle-number sequencer for one radix-2^2 SDF stage. It
//                counts accepted input samples within a 2^LOG_M block. For
//                each sample it issues the twiddle number in the index format
//                of the 1/8-table twiddle converter, together with the
//                multiplier class. It also provides a valid flag delayed by
//                TW_LAT cycles, which marks when the converted twiddle value
//                reaches the multiplier.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LOG_N  : FFT size exponent and twiddle number width (>= 4)
//    LOG_M  : stage block size exponent (3 <= LOG_M <= LOG_N)
//    TW_LAT : tw_addr to converted-twiddle latency in cycles (0..4)
//  Ports
//    i_clk   : master clock
//    i_rst_n : asynchronous active-low reset
//    bus     : sdf_twiddle_addr_gen_if.slave (clear/di_en in, twiddle out)
// ============================================================================
module sdf_twiddle_addr_gen #(
  parameter int LOG_N  = 6,
  parameter int LOG_M  = 6,
  parameter int TW_LAT = 2
) (
  input  wire logic                  i_clk,
  input  wire logic                  i_rst_n,
  sdf_twiddle_addr_gen_if.slave      bus
);

  // A block of 2^LOG_M samples maps onto the full 2^LOG_N twiddle circle.
  // The shift scales the per-block twiddle number up to LOG_N resolution.
  localparam int               c_SHIFT   = LOG_N - LOG_M;
  localparam logic [LOG_M-1:0] c_CNT_MAX = '1;

  logic [LOG_M-1:0] r_cnt;
  logic             r_tw_en;
  logic [LOG_N-1:0] r_tw_addr;
  logic [1:0]       r_tw_sel;
  logic             r_tw_last;

  logic [1:0]       w_sel;
  logic [LOG_M-3:0] w_n;
  logic [LOG_M-1:0] w_prod;
  logic [LOG_N-1:0] w_addr;
  logic             w_last;

  // The two top counter bits are swapped so that the quarters come out in
  // class order 0,2,1,3. This is the bit-reversed order the SDF butterflies
  // deliver.
  assign w_sel  = {r_cnt[LOG_M-2], r_cnt[LOG_M-1]};
  assign w_n    = r_cnt[LOG_M-3:0];
  // The largest product is 3*(2^(LOG_M-2)-1) < 2^LOG_M, so LOG_M bits are
  // enough and the product cannot overflow.
  assign w_prod = LOG_M'(w_n) * LOG_M'(w_sel);
  assign w_addr = LOG_N'(w_prod) << c_SHIFT;
  assign w_last = (r_cnt == c_CNT_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_tw_en   <= 1'b0;
      r_tw_addr <= '0;
      r_tw_sel  <= '0;
      r_tw_last <= 1'b0;
    end else if (bus.i_clear) begin
      // A restart drops the sample offered on the same edge.
      r_cnt     <= '0;
      r_tw_en   <= 1'b0;
      r_tw_last <= 1'b0;
    end else if (bus.i_di_en) begin
      r_cnt     <= r_cnt + LOG_M'(1);
      r_tw_en   <= 1'b1;
      r_tw_addr <= w_addr;
      r_tw_sel  <= w_sel;
      r_tw_last <= w_last;
    end else begin
      // Idle cycle: the counter and the last twiddle hold, so gaps stretch
      // the sequence without skipping or repeating entries.
      r_tw_en   <= 1'b0;
      r_tw_last <= 1'b0;
    end
  end

  assign bus.o_tw_en   = r_tw_en;
  assign bus.o_tw_addr = r_tw_addr;
  assign bus.o_tw_sel  = r_tw_sel;
  assign bus.o_tw_last = r_tw_last;

  // The valid delay line tracks the ROM and converter pipeline. It shifts
  // every cycle, including during clear, so earlier pulses still drain out.
  generate
    if (TW_LAT == 0) begin : g_no_dly
      assign bus.o_val_en = r_tw_en;
    end else begin : g_dly
      logic [TW_LAT-1:0] r_dly;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_dly <= '0;
        end else begin
          r_dly[0] <= r_tw_en;
          for (int i = 1; i < TW_LAT; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end

      assign bus.o_val_en = r_dly[TW_LAT-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sdf_twiddle_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdf_twiddle_addr_gen
//  Description : Bench for sdf_twiddle_addr_gen. Three instances share one
//                stimulus:
//                  A: LOG_N=6, LOG_M=6, TW_LAT=2
//                  B: LOG_N=6, LOG_M=4, TW_LAT=0
//                  C: LOG_N=6, LOG_M=6, TW_LAT=4
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdf_twiddle_addr_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sdf_twiddle_addr_gen_if #(.LOG_N(6)) ifa ();
  sdf_twiddle_addr_gen_if #(.LOG_N(6)) ifb ();
  sdf_twiddle_addr_gen_if #(.LOG_N(6)) ifc ();

  sdf_twiddle_addr_gen #(.LOG_N(6), .LOG_M(6), .TW_LAT(2)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa.slave));
  sdf_twiddle_addr_gen #(.LOG_N(6), .LOG_M(4), .TW_LAT(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb.slave));
  sdf_twiddle_addr_gen #(.LOG_N(6), .LOG_M(6), .TW_LAT(4)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifc.slave));

  typedef struct {
    int       adv;     // unchecked di_en=1 cycles issued before the row
    bit       en;
    bit       clr;
    bit       chk_ad;  // compare address/class on this row
    bit       ex_en;
    bit [5:0] a_addr;
    bit [1:0] a_sel;
    bit       a_last;
    bit [5:0] b_addr;
    bit [1:0] b_sel;
    bit       b_last;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit en, input bit clr);
    ifa.i_di_en = en; ifb.i_di_en = en; ifc.i_di_en = en;
    ifa.i_clear = clr; ifb.i_clear = clr; ifc.i_clear = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Expected class for sample c of a 2^m block, taken from the quarter index.
  function automatic int exp_sel(input int c, input int m);
    int q;
    q = c / (1 << (m - 2));
    case (q)
      0: return 0;
      1: return 2;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int exp_addr(input int c, input int m);
    return (exp_sel(c, m) * (c % (1 << (m - 2)))) << (6 - m);
  endfunction

  initial begin
    // Hand-computed rows. The A-counter position before each row is noted.
    //              adv en clr chk en  aA  sA lA  aB  sB lB
    tbl[0]  = '{ 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, 0}; // idle at c=0
    tbl[1]  = '{ 0, 1, 0, 1, 1,  0, 0, 0,  0, 0, 0}; // c=0
    tbl[2]  = '{ 5, 1, 0, 1, 1,  0, 0, 0, 16, 2, 0}; // c=6
    tbl[3]  = '{ 8, 1, 0, 1, 1,  0, 0, 0, 36, 3, 1}; // c=15
    tbl[4]  = '{ 0, 0, 0, 1, 0,  0, 0, 0, 36, 3, 0}; // gap, hold
    tbl[5]  = '{ 0, 1, 0, 1, 1,  0, 2, 0,  0, 0, 0}; // c=16
    tbl[6]  = '{14, 1, 0, 1, 1, 30, 2, 0, 36, 3, 1}; // c=31
    tbl[7]  = '{ 5, 1, 0, 1, 1,  5, 1, 0,  8, 2, 0}; // c=37
    tbl[8]  = '{10, 0, 0, 1, 0, 15, 1, 0, 36, 3, 0}; // gap after c=47
    tbl[9]  = '{ 0, 1, 0, 1, 1,  0, 3, 0,  0, 0, 0}; // c=48
    tbl[10] = '{14, 1, 0, 1, 1, 45, 3, 1, 36, 3, 1}; // c=63
    tbl[11] = '{ 0, 1, 0, 1, 1,  0, 0, 0,  0, 0, 0}; // wrap to c=0
    tbl[12] = '{36, 1, 1, 0, 0,  0, 0, 0,  0, 0, 0}; // clear at c=37
    tbl[13] = '{ 0, 1, 0, 1, 1,  0, 0, 0,  0, 0, 0}; // restart c=0

    // ---- reset state ----
    drive(1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("rst_tw_en",  int'(ifa.o_tw_en), 0);
    chk("rst_addr",   int'(ifa.o_tw_addr), 0);
    chk("rst_sel",    int'(ifa.o_tw_sel), 0);
    chk("rst_last",   int'(ifa.o_tw_last), 0);
    chk("rst_val_a",  int'(ifa.o_val_en), 0);
    chk("rst_val_b",  int'(ifb.o_val_en), 0);
    chk("rst_val_c",  int'(ifc.o_val_en), 0);
    do_reset();

    // ---- table-driven vectors ----
    foreach (tbl[r]) begin
      drive(1'b1, 1'b0);
      repeat (tbl[r].adv) tick();
      drive(tbl[r].en, tbl[r].clr);
      tick();
      chk($sformatf("tbl%0d_en_a", r), int'(ifa.o_tw_en), int'(tbl[r].ex_en));
      chk($sformatf("tbl%0d_en_b", r), int'(ifb.o_tw_en), int'(tbl[r].ex_en));
      chk($sformatf("tbl%0d_last_a", r), int'(ifa.o_tw_last), int'(tbl[r].a_last));
      chk($sformatf("tbl%0d_last_b", r), int'(ifb.o_tw_last), int'(tbl[r].b_last));
      if (tbl[r].chk_ad) begin
        chk($sformatf("tbl%0d_addr_a", r), int'(ifa.o_tw_addr), int'(tbl[r].a_addr));
        chk($sformatf("tbl%0d_sel_a", r),  int'(ifa.o_tw_sel),  int'(tbl[r].a_sel));
        chk($sformatf("tbl%0d_addr_b", r), int'(ifb.o_tw_addr), int'(tbl[r].b_addr));
        chk($sformatf("tbl%0d_sel_b", r),  int'(ifb.o_tw_sel),  int'(tbl[r].b_sel));
        chk($sformatf("tbl%0d_addr_c", r), int'(ifc.o_tw_addr), int'(tbl[r].a_addr));
      end
    end

    // ---- after the clear: next tw_last 63 samples after the restart sample ----
    for (int k = 1; k < 64; k++) begin
      drive(1'b1, 1'b0);
      tick();
      chk($sformatf("clr_last_k%0d", k), int'(ifa.o_tw_last), (k == 63) ? 1 : 0);
    end

    // ---- full sweep with continuous di_en ----
    do_reset();
    for (int c = 0; c < 64; c++) begin
      drive(1'b1, 1'b0);
      tick();
      chk($sformatf("sw_en_c%0d", c),    int'(ifa.o_tw_en), 1);
      chk($sformatf("sw_addr_c%0d", c),  int'(ifa.o_tw_addr), exp_addr(c, 6));
      chk($sformatf("sw_sel_c%0d", c),   int'(ifa.o_tw_sel), exp_sel(c, 6));
      chk($sformatf("sw_last_c%0d", c),  int'(ifa.o_tw_last), (c == 63) ? 1 : 0);
      chk($sformatf("sw_addrb_c%0d", c), int'(ifb.o_tw_addr), exp_addr(c % 16, 4));
      chk($sformatf("sw_selb_c%0d", c),  int'(ifb.o_tw_sel), exp_sel(c % 16, 4));
      chk($sformatf("sw_lastb_c%0d", c), int'(ifb.o_tw_last), ((c % 16) == 15) ? 1 : 0);
      chk($sformatf("sw_addrc_c%0d", c), int'(ifc.o_tw_addr), exp_addr(c, 6));
    end

    // ---- gapped di_en, 1 on / 2 off ----
    do_reset();
    for (int c = 0; c < 64; c++) begin
      drive(1'b1, 1'b0);
      tick();
      chk($sformatf("gap_en_c%0d", c),   int'(ifa.o_tw_en), 1);
      chk($sformatf("gap_addr_c%0d", c), int'(ifa.o_tw_addr), exp_addr(c, 6));
      drive(1'b0, 1'b0);
      tick();
      chk($sformatf("gap_off1_c%0d", c), int'(ifa.o_tw_en), 0);
      tick();
      chk($sformatf("gap_off2_c%0d", c), int'(ifa.o_tw_en), 0);
      chk($sformatf("gap_hold_c%0d", c), int'(ifa.o_tw_addr), exp_addr(c, 6));
    end

    // ---- latency / val_en for TW_LAT = 0, 2, 4 ----
    do_reset();
    tick();
    drive(1'b1, 1'b0);
    tick();
    for (int off = 1; off <= 7; off++) begin
      if (off == 1) drive(1'b0, 1'b0);
      chk($sformatf("lat_en_o%0d", off),   int'(ifa.o_tw_en),  (off == 1) ? 1 : 0);
      chk($sformatf("lat_val0_o%0d", off), int'(ifb.o_val_en), (off == 1) ? 1 : 0);
      chk($sformatf("lat_val2_o%0d", off), int'(ifa.o_val_en), (off == 3) ? 1 : 0);
      chk($sformatf("lat_val4_o%0d", off), int'(ifc.o_val_en), (off == 5) ? 1 : 0);
      tick();
    end

    // ---- asynchronous reset in the middle of a frame ----
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    chk("mid_pre_addr", int'(ifa.o_tw_addr), 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en",    int'(ifa.o_tw_en), 0);
    chk("mid_rst_addr",  int'(ifa.o_tw_addr), 0);
    chk("mid_rst_sel",   int'(ifa.o_tw_sel), 0);
    chk("mid_rst_last",  int'(ifa.o_tw_last), 0);
    chk("mid_rst_val_a", int'(ifa.o_val_en), 0);
    chk("mid_rst_val_c", int'(ifc.o_val_en), 0);
    chk("mid_rst_addrb", int'(ifb.o_tw_addr), 0);
    drive(1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("mid_drop_a%0d", k), int'(ifa.o_val_en), 0);
      chk($sformatf("mid_drop_c%0d", k), int'(ifc.o_val_en), 0);
    end
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    chk("mid_first_en",   int'(ifa.o_tw_en), 1);
    chk("mid_first_addr", int'(ifa.o_tw_addr), 0);
    chk("mid_first_sel",  int'(ifa.o_tw_sel), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdf_twiddle_addr_gen.md
# sdf_twiddle_addr_gen

Twiddle-number sequencer for one radix-2² SDF stage. It tracks the stage's input sample position and issues the twiddle number each sample needs, in the index format the 1/8-table twiddle converter consumes. It also emits a delayed valid that marks when the converted twiddle value is ready at the multiplier. It sits upstream of the twiddle ROM and converter, and is driven by the same data-enable that feeds the stage.

## Interface
- LOG_N, 6: FFT size exponent; twiddle number width. Must be ≥ 4.
- LOG_M, 6: stage block size exponent. Must satisfy 3 ≤ LOG_M ≤ LOG_N.
- TW_LAT, 2: cycles from tw_addr to a valid converted twiddle value (ROM plus converter registers). Allowed range is 0..4.
- clock  input  1  master clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous frame restart; takes priority over di_en.
- di_en  input  1  input sample valid for this stage.
- tw_en  output  1  tw_addr and tw_sel valid.
- tw_addr  output  LOG_N  twiddle number.
- tw_sel  output  2  twiddle multiplier class, 0..3.
- tw_last  output  1  asserted with tw_en on the last sample of an LOG_M block.
- val_en  output  1  tw_en delayed by TW_LAT cycles; converted twiddle valid.

## Operation
- Internal sample counter cnt, LOG_M bits, reset to 0.
- On an edge with clear=1: cnt goes to 0, tw_en goes to 0, tw_last goes to 0. The delay line keeps shifting (its input is 0).
- On an edge with clear=0 and di_en=1, for the current value c of cnt:
  - cnt advances to c+1, wrapping from 2^LOG_M−1 to 0.
  - tw_sel = {c[LOG_M−2], c[LOG_M−1]}. This bit swap gives the class order 0,2,1,3 across the four quarters.
  - n = c[LOG_M−3:0].
  - tw_addr = (n × tw_sel) << (LOG_N−LOG_M). The product is computed in LOG_M bits; max 3×(2^(LOG_M−2)−1) < 2^LOG_M, so there is no overflow. The result is truncated to LOG_N bits.
  - tw_en = 1.
  - tw_last = 1 iff c = 2^LOG_M−1.
- On an edge with clear=0 and di_en=0:
  - cnt holds.
  - tw_en = 0 and tw_last = 0.
  - tw_addr and tw_sel hold their last values.
- val_en delay line:
  - TW_LAT-stage shift register fed by tw_en, so val_en(t) = tw_en(t−TW_LAT).
  - TW_LAT=0 means val_en = tw_en combinationally.
- Gaps in di_en stretch the sequence but never skip or repeat a twiddle number.

## Timing
- Latency: di_en sampled at edge k gives tw_en/tw_addr/tw_sel/tw_last valid after edge k, i.e. during cycle k+1.
- val_en is asserted in cycle k+1+TW_LAT.
- Reset (asynchronous assert, reset=0): immediately forces cnt=0, tw_en=0, tw_addr=0, tw_sel=0, tw_last=0, val_en=0, and all delay stages to 0.
- Reset release: the first di_en edge after release produces twiddle number 0.
- Reset mid-frame: the frame is abandoned. There is no partial-frame completion, and in-flight val_en pulses are dropped.
- clear and di_en together: clear wins. That sample is discarded (tw_en=0) and the next di_en produces c=0.
- Wrap-around: the edge taking c=2^LOG_M−1 asserts tw_last. The following di_en edge starts at c=0 with no bubble.
- Continuous di_en: tw_en is held high every cycle. tw_last is a one-cycle pulse every 2^LOG_M cycles.

## Test plan
- **Full sweep, LOG_N=LOG_M=6, continuous di_en for 64 cycles from reset:**
  - c=0..15: tw_sel=0, tw_addr=0.
  - c=16..31: tw_sel=2, tw_addr=2n (c=31 gives 30).
  - c=32..47: tw_sel=1, tw_addr=n.
  - c=48..63: tw_sel=3, tw_addr=3n (c=63 gives 45).
  - tw_last only on c=63.
- **Sub-stage, LOG_N=6, LOG_M=4:**
  - c=15 gives tw_sel=3, tw_addr=36.
  - c=6 gives tw_sel=2, tw_addr=16.
  - tw_last pulses every 16 samples.
- **Gapped di_en (1-on/2-off, LOG_M=6):** tw_addr follows the same 64-entry sequence as the sweep test, and tw_en pulses exactly once per accepted sample.
- **Latency / val_en, TW_LAT=0,2,4:**
  - Single di_en pulse at edge k gives tw_en in cycle k+1.
  - val_en is high exactly in cycle k+1+TW_LAT.
- **clear at c=37 with di_en=1:**
  - tw_en=0 that cycle.
  - Next di_en gives tw_addr=0, tw_sel=0.
  - tw_last next appears 64 samples later.
- **Async reset asserted mid-frame between edges:**
  - All outputs go to 0 before the next edge, and in-flight val_en is lost.
  - After release, the first sample gives tw_addr=0.
